// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_wb_stage_pkg                                         |
// | Description : Shared types and constants for the memory-access stage   |
// |               and MEM/WB pipeline register of the RV32 pipeline.       |
// |               XLEN      - datapath width                               |
// |               REG_IDX_W - register-file index width                    |
// |               mem_state_t - memory-access FSM state encoding           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package mem_wb_stage_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   // IDLE: ready to accept an op; WAIT: counting down extra latency cycles.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_t;

endpackage : mem_wb_stage_pkg
`default_nettype wire

// File: rtl/mem_wb_stage_data_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : data_ram                                                 |
// | Description : Word-organised data RAM, 2**ADDR_BITS words of XLEN      |
// |               bits. Synchronous write, asynchronous read on the same   |
// |               address, so a same-cycle read returns the old word.      |
// | Ports       : clk     - clock                                          |
// |               i_we    - write enable (sampled on rising edge)          |
// |               i_addr  - word address (read and write)                  |
// |               i_wdata - write data                                     |
// |               o_rdata - combinational read data                        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module data_ram
   import mem_wb_stage_pkg::*;
#(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic [XLEN-1:0]      i_wdata,
   output logic [XLEN-1:0]      o_rdata
);

   // Contents are deliberately not reset.
   logic [XLEN-1:0] r_mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule : data_ram
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_wb_stage                                             |
// | Description : Memory-access stage plus MEM/WB pipeline register.       |
// |               Performs loads/stores against an internal word RAM with  |
// |               MEM_LATENCY extra wait cycles per access, signalled      |
// |               upstream through Stall_M, and registers the write-back   |
// |               result (also the forwarding source Result_W).            |
// | Ports       : clk, reset    - clock, synchronous active-high reset     |
// |               ALUResult_M   - ALU result / byte address                |
// |               Rd2_M         - store data                               |
// |               Rd_M          - destination register                     |
// |               RegWrite_M, MemWrite_M, MemRead_M, MemToReg_M - control  |
// |               Stall_M       - combinational, M-stage op not finished   |
// |               Result_W, Rd_W, RegWrite_W - registered write-back       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int ADDR_BITS   = 8,
   parameter int MEM_LATENCY = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [XLEN-1:0]      ALUResult_M,
   input  logic [XLEN-1:0]      Rd2_M,
   input  logic [REG_IDX_W-1:0] Rd_M,
   input  logic                 RegWrite_M,
   input  logic                 MemWrite_M,
   input  logic                 MemRead_M,
   input  logic                 MemToReg_M,
   output logic                 Stall_M,
   output logic [XLEN-1:0]      Result_W,
   output logic [REG_IDX_W-1:0] Rd_W,
   output logic                 RegWrite_W
);

   // Counter preload on entering WAIT; only meaningful when MEM_LATENCY > 0.
   localparam logic [3:0] c_lat_minus1 = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

   mem_state_t             r_state;
   mem_state_t             w_state_next;
   logic [3:0]             r_cnt;
   logic [3:0]             w_cnt_next;
   logic                   w_mem_op;
   logic                   w_stall;
   logic                   w_ram_we;
   logic [ADDR_BITS-1:0]   w_idx;
   logic [XLEN-1:0]        w_ram_rdata;
   logic                   w_unused_addr_bits;

   // Byte offset and bits above the RAM size are ignored: addresses wrap.
   assign w_idx              = ALUResult_M[ADDR_BITS+1:2];
   assign w_unused_addr_bits = ^{ALUResult_M[XLEN-1:ADDR_BITS+2], ALUResult_M[1:0]};

   assign w_mem_op = MemRead_M | MemWrite_M;

   // ---------------------------------------------------------------------
   // Latency FSM: next state and stall
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_stall      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_mem_op && (MEM_LATENCY != 0)) begin
               w_stall      = 1'b1;
               w_state_next = ST_WAIT;
               w_cnt_next   = c_lat_minus1;
            end
         end
         ST_WAIT: begin
            if (r_cnt != 4'd0) begin
               w_stall    = 1'b1;
               w_cnt_next = r_cnt - 4'd1;
            end else begin
               // Completion cycle; the next op restarts from IDLE.
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   assign Stall_M = w_stall;

   // ---------------------------------------------------------------------
   // Data RAM: a store commits only on its completion cycle, and a reset
   // landing on that cycle discards it.
   // ---------------------------------------------------------------------
   assign w_ram_we = MemWrite_M & ~w_stall & ~reset;

   data_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_idx),
      .i_wdata (Rd2_M),
      .o_rdata (w_ram_rdata)
   );

   // ---------------------------------------------------------------------
   // MEM/WB register: captures on completion, inserts a bubble while stalled
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         Result_W   <= '0;
         Rd_W       <= '0;
         RegWrite_W <= 1'b0;
      end else if (!w_stall) begin
         // Read is combinational, so load+store on one op sees the old word.
         Result_W   <= MemToReg_M ? w_ram_rdata : ALUResult_M;
         Rd_W       <= Rd_M;
         RegWrite_W <= RegWrite_M & (Rd_M != '0);
      end else begin
         RegWrite_W <= 1'b0;
      end
   end

endmodule : mem_wb_stage
`default_nettype wire
